// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
//   fetch_state_t : BOOT (first cycle out of reset), RUN (streaming),
//                   FLUSH (one dead cycle after a redirect)
//   RESET_PC_DFLT : default program counter loaded at reset (word index)
//   PC_STEP_DFLT  : default sequential increment (imem is word-indexed)
package h2bp;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DFLT = 32'd0;
  localparam logic [31:0] PC_STEP_DFLT  = 32'd1;

endpackage

// File: rtl/fetch_ctrl_skid.sv
// One-entry skid buffer holding an instruction and its pc while decode stalls.
//   clk, rst     : clock, synchronous active-high reset (empties the entry)
//   load         : capture data_in/pc_in into the entry
//   clear        : empty the entry (wins over load)
//   data_in/pc_in: instruction word and pc to capture
//   full         : entry holds a valid instruction
//   data/pc      : held instruction word and pc
module fetch_skid
  import h2bp::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] data,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
      pc   <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= data_in;
      pc   <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the pc, presents it to imem every cycle, flushes imem
// on redirects and hides imem's one-cycle read latency from decode with a
// one-entry skid buffer.
//   clk, rst      : clock, synchronous active-high reset
//   pc_o          : fetch address to imem
//   flush_o       : imem flush (rst | br_taken_i)
//   instr_i       : imem data for the address presented last cycle
//   br_taken_i    : redirect request from execute, target in br_target_i
//   id_stall_i    : decode cannot accept this cycle
//   if_valid_o    : if_instr_o/if_pc_o carry a real instruction
//   if_instr_o    : instruction to decode, if_pc_o its pc
//   fetch_cnt_o   : instructions accepted by decode
//   bubble_cnt_o  : cycles without a valid instruction outside reset
module fetch_ctrl
  import h2bp::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        flush_o,
  input  logic [31:0] instr_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        id_stall_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q;   // address imem is answering this cycle
  logic [31:0]  fetch_cnt_q, bubble_cnt_q;

  logic         skid_full, skid_load, skid_clear;
  logic [31:0]  skid_data, skid_pc;
  logic         accept;

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .data_in (if_instr_o),
    .pc_in   (if_pc_o),
    .full    (skid_full),
    .data    (skid_data),
    .pc      (skid_pc)
  );

  assign pc_o         = pc_q;
  assign flush_o      = rst | br_taken_i;
  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

  // A held instruction takes precedence over the imem stream; the stream
  // behind it is re-fetched because pc_q stays put while stalled.
  assign if_instr_o = skid_full ? skid_data : instr_i;
  assign if_pc_o    = skid_full ? skid_pc   : inflight_pc_q;
  assign if_valid_o = (state_q == RUN) && !br_taken_i;

  assign accept     = if_valid_o && !id_stall_i;
  assign skid_load  = if_valid_o && id_stall_i && !skid_full && !br_taken_i;
  assign skid_clear = accept || br_taken_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (br_taken_i) begin
      state_d = FLUSH;
      pc_d    = br_target_i;
    end else begin
      if (state_q != RUN) state_d = RUN;
      // Advance unless a valid instruction is being held back by decode.
      if (!if_valid_o || !id_stall_i) pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      fetch_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= pc_q;
      if (accept)      fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (!if_valid_o) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural word-indexed imem.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, br_taken, stall;
  logic [31:0] br_target, pc, instr;
  logic        flush, if_valid;
  logic [31:0] if_instr, if_pc, fetch_cnt, bubble_cnt;

  logic [31:0] mem [16];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_o         (pc),
    .flush_o      (flush),
    .instr_i      (instr),
    .br_taken_i   (br_taken),
    .br_target_i  (br_target),
    .id_stall_i   (stall),
    .if_valid_o   (if_valid),
    .if_instr_o   (if_instr),
    .if_pc_o      (if_pc),
    .fetch_cnt_o  (fetch_cnt),
    .bubble_cnt_o (bubble_cnt)
  );

  // imem: one-cycle read, returns 0 for a flushed cycle
  initial instr = '0;
  always @(posedge clk) instr <= flush ? 32'd0 : mem[pc[3:0]];

  function automatic logic [31:0] mv(input int i);
    return (i == 9) ? 32'h0840_0003 : 32'h1000_0000 + i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, apply inputs, settle before checking.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_target = t;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = mv(i);
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flush", {31'd0, flush}, 32'd1);
    chk("rst_pc", pc, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_fcnt", fetch_cnt, 32'd0);
    chk("rst_bcnt", bubble_cnt, 32'd0);

    // cycle 0: BOOT
    rst = 1'b0; #1;
    chk("c0_valid", {31'd0, if_valid}, 32'd0);
    chk("c0_flush", {31'd0, flush}, 32'd0);
    chk("c0_pc", pc, 32'd0);
    // cycles 1,2: streaming
    for (int c = 1; c <= 2; c++) begin
      step(0, 0, 0, 0);
      chk("run_valid", {31'd0, if_valid}, 32'd1);
      chk("run_ifpc", if_pc, c - 1);
      chk("run_instr", if_instr, mv(c - 1));
      chk("run_pc", pc, c);
    end
    // cycles 3..5: stall while if_pc=2
    for (int c = 3; c <= 5; c++) begin
      step(0, 1, 0, 0);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_ifpc", if_pc, 32'd2);
      chk("stall_instr", if_instr, mv(2));
      chk("stall_pc", pc, 32'd3);
      chk("stall_fcnt", fetch_cnt, 32'd2);
    end
    chk("boot_bcnt", bubble_cnt, 32'd1);
    // cycle 6: release, held 2 accepted; 7: 3; 8: 4
    for (int c = 6; c <= 7; c++) begin
      step(0, 0, 0, 0);
      chk("rel_ifpc", if_pc, c - 4);
      chk("rel_instr", if_instr, mv(c - 4));
      chk("rel_fcnt", fetch_cnt, c - 4);
    end
    // cycle 8: redirect to 9 while if_pc=4
    step(0, 0, 1, 32'd9);
    chk("br_flush", {31'd0, flush}, 32'd1);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    chk("br_fcnt", fetch_cnt, 32'd4);
    step(0, 0, 0, 0);
    chk("fl_valid", {31'd0, if_valid}, 32'd0);
    chk("fl_pc", pc, 32'd9);
    chk("fl_flush", {31'd0, flush}, 32'd0);
    // cycle 10: target arrives; stall to fill skid
    step(0, 1, 0, 0);
    chk("tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("tgt_ifpc", if_pc, 32'd9);
    chk("tgt_instr", if_instr, 32'h0840_0003);
    chk("tgt_bcnt", bubble_cnt, 32'd3);
    // cycle 11: redirect + stall with skid full
    step(0, 1, 1, 32'd5);
    chk("brst_flush", {31'd0, flush}, 32'd1);
    chk("brst_valid", {31'd0, if_valid}, 32'd0);
    step(0, 1, 0, 0);
    chk("brst_fl_valid", {31'd0, if_valid}, 32'd0);
    chk("brst_fl_pc", pc, 32'd5);
    step(0, 0, 0, 0);
    chk("brst_valid2", {31'd0, if_valid}, 32'd1);
    chk("brst_ifpc", if_pc, 32'd5);
    chk("brst_instr", if_instr, mv(5));
    chk("brst_bcnt", bubble_cnt, 32'd5);
    chk("brst_fcnt", fetch_cnt, 32'd4);
    // cycle 14: redirect to the top of the address space
    step(0, 0, 1, 32'hFFFF_FFFF);
    chk("wr_fcnt", fetch_cnt, 32'd5);
    step(0, 0, 0, 0);
    chk("wr_pcmax", pc, 32'hFFFF_FFFF);
    step(0, 0, 0, 0);
    chk("wr_pc0", pc, 32'd0);
    chk("wr_ifpc", if_pc, 32'hFFFF_FFFF);
    chk("wr_instr", if_instr, mv(15));
    // cycle 17: stall at if_pc=0, then reset mid-stall
    step(0, 1, 0, 0);
    chk("wr2_ifpc", if_pc, 32'd0);
    chk("wr2_instr", if_instr, mv(0));
    step(1, 1, 0, 0);
    chk("rs_held", if_pc, 32'd0);
    chk("rs_flush", {31'd0, flush}, 32'd1);
    step(1, 1, 0, 0);
    chk("rs_pc", pc, 32'd0);
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_fcnt", fetch_cnt, 32'd0);
    chk("rs_bcnt", bubble_cnt, 32'd0);
    chk("rs_instr", if_instr, 32'd0);
    rst = 1'b0; stall = 1'b0; #1;
    step(0, 0, 0, 0);
    chk("rs2_valid", {31'd0, if_valid}, 32'd1);
    chk("rs2_ifpc", if_pc, 32'd0);
    chk("rs2_instr", if_instr, mv(0));
    chk("rs2_bcnt", bubble_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
